// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch constants, state type and address helper
package fetch_stage_pkg;
    localparam logic [31:0] BIOS_BASE = 32'h4000_0000;
    localparam logic [31:0] NOP_ADDI = 32'h0000_0013;
    localparam int FETCH_CNT_W = 32;
    typedef enum logic {S_BOOT, S_RUN} fetchState_t;
    function automatic logic [31:0] alignWord(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, IMEM and decode-side signals of the fetch stage
interface fetch_stage_if import fetch_stage_pkg::*; #(parameter int CNT_W = FETCH_CNT_W);
    logic stall;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic inst_valid;
    logic misalign_err;
    logic [CNT_W-1:0] fetch_cnt;
    modport master(
        input stall, redirect_valid, redirect_pc, imem_dout,
        output imem_addr, inst_out, pc_out, inst_valid, misalign_err, fetch_cnt
    );
    modport slave(
        output stall, redirect_valid, redirect_pc, imem_dout,
        input imem_addr, inst_out, pc_out, inst_valid, misalign_err, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage_perf_ctr.sv
// fetch_stage_perf_ctr: wrapping event counter for the perf CSR
module fetch_stage_perf_ctr #(parameter int W = 32) (
    input logic clk,
    input logic rst,
    input logic en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk)
        count <= rst ? '0 : count + W'(en);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, sync IMEM address, decode-side instruction/pc/valid and fetch counter
module fetch_stage import fetch_stage_pkg::*; #(
    parameter logic [31:0] RESET_PC = BIOS_BASE,
    parameter logic [31:0] NOP_INSTR = NOP_ADDI,
    parameter int CNT_W = FETCH_CNT_W
) (
    input logic clk,
    input logic rst,
    fetch_stage_if.master bus
);
    fetchState_t state;
    logic [31:0] pcQ;
    logic [31:0] nextPc;
    logic misalignQ;
    logic valid;
    always_comb begin
        nextPc = rst ? RESET_PC
               : bus.redirect_valid ? alignWord(bus.redirect_pc)
               : (state == S_BOOT || bus.stall) ? pcQ
               : pcQ + 32'd4;
        valid = !rst && state == S_RUN && !bus.redirect_valid;
    end
    always_ff @(posedge clk) begin
        state <= rst ? S_BOOT : S_RUN;
        pcQ <= nextPc;
        misalignQ <= !rst && bus.redirect_valid && |bus.redirect_pc[1:0];
    end
    assign bus.imem_addr = nextPc;
    assign bus.pc_out = rst ? RESET_PC : pcQ;
    assign bus.inst_valid = valid;
    assign bus.inst_out = valid ? bus.imem_dout : NOP_INSTR;
    assign bus.misalign_err = misalignQ;
    fetch_stage_perf_ctr #(.W(CNT_W)) perf (
        .clk(clk),
        .rst(rst),
        .en(valid && !bus.stall),
        .count(bus.fetch_cnt)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a cycle-level fetch model
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'h4000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nChecks = 0;
    int nPass = 0;
    logic [31:0] mPc = RPC;
    int mSince = 0;
    logic [31:0] mCnt = '0;
    logic mMis = 1'b0;
    fetch_stage_if #(.CNT_W(32)) bus();
    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        rst = r;
        bus.stall = s;
        bus.redirect_valid = rv;
        bus.redirect_pc = rp;
        @(negedge clk);
    endtask

    always @(posedge clk) bus.imem_dout <= memf(bus.imem_addr);

    always @(posedge clk) begin
        if (rst) begin
            mPc = RPC;
            mSince = 0;
            mCnt = '0;
            mMis = 1'b0;
        end else begin
            if (mSince > 0 && !bus.redirect_valid && !bus.stall) mCnt = mCnt + 1;
            mMis = bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00;
            if (bus.redirect_valid) mPc = bus.redirect_pc & ~32'h3;
            else if (mSince > 0 && !bus.stall) mPc = mPc + 32'd4;
            if (mSince < 2) mSince++;
        end
    end

    always @(negedge clk) begin
        logic ev;
        logic [31:0] ea;
        if (rst) begin
            chk("addr_rst", bus.imem_addr, RPC);
            chk("valid_rst", {31'b0, bus.inst_valid}, 32'd0);
            chk("inst_rst", bus.inst_out, NOP);
            chk("pc_rst", bus.pc_out, RPC);
        end else begin
            ev = mSince > 0 && !bus.redirect_valid;
            ea = bus.redirect_valid ? (bus.redirect_pc & ~32'h3)
               : (mSince > 0 && !bus.stall) ? mPc + 32'd4 : mPc;
            chk("addr", bus.imem_addr, ea);
            chk("valid", {31'b0, bus.inst_valid}, {31'b0, ev});
            chk("inst", bus.inst_out, ev ? memf(mPc) : NOP);
            chk("pc", bus.pc_out, mPc);
            chk("misalign", {31'b0, bus.misalign_err}, {31'b0, mMis});
            chk("cnt", bus.fetch_cnt, mCnt);
        end
    end

    initial begin
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (3) cyc(1, 0, 0, 0);
        chk("lit_rst_addr", bus.imem_addr, 32'h4000_0000);
        cyc(0, 0, 0, 0);
        chk("lit_boot_valid", {31'b0, bus.inst_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("lit_pc0", bus.pc_out, 32'h4000_0000);
        chk("lit_inst0", bus.inst_out, 32'h0000_FFFF);
        cyc(0, 0, 0, 0);
        chk("lit_pc4", bus.pc_out, 32'h4000_0004);
        repeat (2) begin
            cyc(0, 1, 0, 0);
            chk("lit_stall_pc", bus.pc_out, 32'h4000_0008);
            chk("lit_stall_addr", bus.imem_addr, 32'h4000_0008);
            chk("lit_stall_cnt", bus.fetch_cnt, 32'd2);
        end
        cyc(0, 0, 0, 0);
        chk("lit_release_addr", bus.imem_addr, 32'h4000_000C);
        cyc(0, 0, 1, 32'h4000_0100);
        chk("lit_redir_pc", bus.pc_out, 32'h4000_000C);
        chk("lit_redir_valid", {31'b0, bus.inst_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("lit_tgt_pc", bus.pc_out, 32'h4000_0100);
        chk("lit_tgt_inst", bus.inst_out, 32'h0100_FEFF);
        chk("lit_tgt_cnt", bus.fetch_cnt, 32'd3);
        cyc(0, 1, 1, 32'h4000_0200);
        cyc(0, 0, 0, 0);
        chk("lit_rs_pc", bus.pc_out, 32'h4000_0200);
        cyc(0, 0, 1, 32'h4000_0302);
        chk("lit_mis_addr", bus.imem_addr, 32'h4000_0300);
        cyc(0, 0, 0, 0);
        chk("lit_mis_pc", bus.pc_out, 32'h4000_0300);
        chk("lit_mis_err", {31'b0, bus.misalign_err}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("lit_mis_clr", {31'b0, bus.misalign_err}, 32'd0);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
        chk("lit_wrap_addr", bus.imem_addr, 32'h0000_0000);
        cyc(0, 0, 0, 0);
        chk("lit_wrap_next", bus.pc_out, 32'h0000_0000);
        chk("lit_wrap_err", {31'b0, bus.misalign_err}, 32'd0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("lit_rr_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("lit_rr_cnt", bus.fetch_cnt, 32'd0);
        chk("lit_rr_pc", bus.pc_out, 32'h4000_0000);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = $urandom;
            if ($urandom_range(15) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
            cyc($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, rp);
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
